fios_pe_ctrl: RTL and testbench

- Sequencer for one FIOS Montgomery PE (17-bit word, non-cascaded, 3-input DSP variant).
- Generates per-cycle datapath control: mux selects, OPMODE, CREG/a/m register enables, RES_delay enable, and word indices for a, b and p operand fetch.
- Sits at the head of the PE chain. Downstream PEs receive delayed copies of its control through the existing chain registers.
- Runs S outer iterations of the FIOS loop per start, then signals done.

---
 rtl/fios_ctrl_pkg.sv | 18 +
 rtl/fios_pe_ctrl.sv | 132 +++++++++++++
 tb/tb_fios_pe_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fios_ctrl_pkg.sv
// fios_ctrl_pkg: shared states, DSP opmodes and PE mux encodings for the FIOS PE sequencer
package fios_ctrl_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD_A, ST_AB0, ST_WAIT_T, ST_MUL_M,
    ST_WAIT_M, ST_MP0, ST_INNER, ST_DRAIN, ST_DONE
  } state_t;
  localparam logic [6:0] OPM_IDLE = 7'b0000000;
  localparam logic [6:0] OPM_AB   = 7'b0000101;
  localparam logic [6:0] OPM_AB_C = 7'b0110101;
  localparam logic [1:0] MUXA_AREG = 2'd0;
  localparam logic [1:0] MUXA_RES  = 2'd1;
  localparam logic [1:0] MUXA_MREG = 2'd2;
  localparam logic [1:0] MUXB_B      = 2'd0;
  localparam logic [1:0] MUXB_PPRIME = 2'd1;
  localparam logic [1:0] MUXB_P      = 2'd2;
  localparam logic [1:0] MUXC_CIN    = 2'd0;
  localparam logic [1:0] MUXC_RESDLY = 2'd1;
endpackage

// File: rtl/fios_pe_ctrl.sv
// fios_pe_ctrl: FIOS Montgomery PE sequencer. start_i launches S outer iterations;
// outputs (all registered): busy_o/done_o status, a_idx_o/bp_idx_o word indices,
// a_reg_en_o/m_reg_en_o/CREG_en_o/RES_delay_en_o enables, mux_*_sel_o selects, OPMODE_o.
module fios_pe_ctrl
  import fios_ctrl_pkg::*;
#(
  parameter int S     = 4,
  parameter int ABREG = 1,
  parameter int MREG  = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [$clog2(S)-1:0] a_idx_o,
  output logic [$clog2(S)-1:0] bp_idx_o,
  output logic                 a_reg_en_o,
  output logic                 m_reg_en_o,
  output logic [1:0]           mux_A_sel_o,
  output logic [1:0]           mux_B_sel_o,
  output logic [1:0]           mux_C_sel_o,
  output logic                 CREG_en_o,
  output logic [6:0]           OPMODE_o,
  output logic                 RES_delay_en_o
);
  localparam int L  = 1 + ABREG + MREG;
  localparam int IW = $clog2(S);
  localparam logic [IW-1:0] LAST = IW'(S - 1);
  state_t state, ns;
  logic [IW-1:0] i, j, ni, nj;
  logic [1:0] w, nw;
  logic sub, nsub, mp, abc;
  assign a_idx_o  = i;
  assign bp_idx_o = j;
  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    ns = state;
    ni = i;
    nj = j;
    nw = w;
    nsub = sub;
    case (state)
      ST_IDLE: if (start_i) begin
        ns = ST_LOAD_A;
        ni = '0;
      end
      ST_LOAD_A: begin
        ns = ST_AB0;
        nj = '0;
      end
      ST_AB0: begin
        ns = (L > 1) ? ST_WAIT_T : ST_MUL_M;
        nw = '0;
      end
      ST_WAIT_T: begin
        ns = (w == 2'(L - 2)) ? ST_MUL_M : ST_WAIT_T;
        nw = w + 2'd1;
      end
      ST_MUL_M: begin
        ns = (L > 1) ? ST_WAIT_M : ST_MP0;
        nw = '0;
      end
      ST_WAIT_M: begin
        ns = (w == 2'(L - 2)) ? ST_MP0 : ST_WAIT_M;
        nw = w + 2'd1;
      end
      ST_MP0: begin
        ns = ST_INNER;
        nj = IW'(1);
        nsub = 1'b0;
      end
      // The end-of-iteration decision is folded into the last MP_j cycle.
      ST_INNER: if (!sub) nsub = 1'b1;
      else if (j != LAST) begin
        nj = j + IW'(1);
        nsub = 1'b0;
      end else if (i == LAST) begin
        ns = ST_DRAIN;
        nw = '0;
      end else begin
        ns = ST_LOAD_A;
        ni = i + IW'(1);
      end
      ST_DRAIN: begin
        ns = (w == 2'(L - 1)) ? ST_DONE : ST_DRAIN;
        nw = w + 2'd1;
      end
      ST_DONE: ns = ST_IDLE;
      default: ns = ST_IDLE;
    endcase
  end
  assign mp  = ns == ST_MP0 || (ns == ST_INNER && nsub);
  assign abc = ns inside {ST_AB0, ST_MP0, ST_INNER};
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      i <= '0;
      j <= '0;
      w <= '0;
      sub <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      a_reg_en_o <= 1'b0;
      m_reg_en_o <= 1'b0;
      mux_A_sel_o <= MUXA_AREG;
      mux_B_sel_o <= MUXB_B;
      mux_C_sel_o <= MUXC_CIN;
      CREG_en_o <= 1'b0;
      OPMODE_o <= OPM_IDLE;
      RES_delay_en_o <= 1'b0;
    end else begin
      state <= ns;
      i <= ni;
      j <= nj;
      w <= nw;
      sub <= nsub;
      busy_o <= !(ns inside {ST_IDLE, ST_DONE});
      done_o <= ns == ST_DONE;
      a_reg_en_o <= ns == ST_LOAD_A;
      m_reg_en_o <= ns == ST_MP0;
      mux_A_sel_o <= mp ? MUXA_MREG : (ns == ST_MUL_M) ? MUXA_RES : MUXA_AREG;
      mux_B_sel_o <= mp ? MUXB_P : (ns == ST_MUL_M) ? MUXB_PPRIME : MUXB_B;
      mux_C_sel_o <= mp ? MUXC_RESDLY : MUXC_CIN;
      CREG_en_o <= abc;
      OPMODE_o <= abc ? OPM_AB_C : (ns == ST_MUL_M) ? OPM_AB : OPM_IDLE;
      // Hold t for the m multiply: first WAIT_M cycle, or MUL_M itself when there is no wait.
      RES_delay_en_o <= (ns == ST_INNER && nsub) || (ns == ST_WAIT_M && nw == 2'd0) ||
                        (L == 1 && ns == ST_MUL_M);
    end
  end
endmodule

// File: tb/tb_fios_pe_ctrl.sv
// tb_fios_pe_ctrl: checks two fios_pe_ctrl configurations cycle by cycle against a position-in-run model
module tb_fios_pe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, st_a, rst_b, st_b;
  logic busy_a, done_a, aen_a, men_a, ce_a, rd_a;
  logic [1:0] ai_a, bi_a, ma_a, mb_a, mc_a;
  logic [6:0] op_a;
  logic busy_b, done_b, aen_b, men_b, ce_b, rd_b;
  logic [0:0] ai_b, bi_b;
  logic [1:0] ma_b, mb_b, mc_b;
  logic [6:0] op_b;
  fios_pe_ctrl #(.S(4), .ABREG(1), .MREG(1)) u_a (
    .clock_i(clk), .reset_i(rst_a), .start_i(st_a), .busy_o(busy_a), .done_o(done_a),
    .a_idx_o(ai_a), .bp_idx_o(bi_a), .a_reg_en_o(aen_a), .m_reg_en_o(men_a),
    .mux_A_sel_o(ma_a), .mux_B_sel_o(mb_a), .mux_C_sel_o(mc_a), .CREG_en_o(ce_a),
    .OPMODE_o(op_a), .RES_delay_en_o(rd_a));
  fios_pe_ctrl #(.S(2), .ABREG(0), .MREG(0)) u_b (
    .clock_i(clk), .reset_i(rst_b), .start_i(st_b), .busy_o(busy_b), .done_o(done_b),
    .a_idx_o(ai_b), .bp_idx_o(bi_b), .a_reg_en_o(aen_b), .m_reg_en_o(men_b),
    .mux_A_sel_o(ma_b), .mux_B_sel_o(mb_b), .mux_C_sel_o(mc_b), .CREG_en_o(ce_b),
    .OPMODE_o(op_b), .RES_delay_en_o(rd_b));
  int passed = 0, total = 0, cyc = 0;
  int s_of[2] = '{4, 2};
  int l_of[2] = '{3, 1};
  int k[2] = '{0, 0};
  int ah[2] = '{0, 0};
  int bh[2] = '{0, 0};
  task automatic chk(input string tag, input logic [30:0] got, input logic [30:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [30:0] pk(logic bz, logic dn, logic [5:0] a, logic [5:0] b,
      logic ae, logic me, logic [1:0] ma, logic [1:0] mb, logic [1:0] mc, logic ce,
      logic [6:0] op, logic rd);
    return {bz, dn, a, b, ae, me, ma, mb, mc, ce, op, rd};
  endfunction
  function automatic logic [30:0] obs(int w);
    if (w == 0)
      return pk(busy_a, done_a, {4'b0, ai_a}, {4'b0, bi_a}, aen_a, men_a, ma_a, mb_a, mc_a,
                ce_a, op_a, rd_a);
    return pk(busy_b, done_b, {5'b0, ai_b}, {5'b0, bi_b}, aen_b, men_b, ma_b, mb_b, mc_b,
              ce_b, op_b, rd_b);
  endfunction
  // Expected outputs k cycles after start was accepted, from iteration arithmetic.
  function automatic logic [30:0] exp_at(int s, int l, int k, int bh);
    int t, p, q;
    logic bz, dn, ae, me, ce, rd;
    logic [1:0] ma, mb, mc;
    logic [6:0] op;
    logic [5:0] a, b;
    t = 2 * l + 2 * s;
    bz = 1'b1; dn = 1'b0; ae = 1'b0; me = 1'b0; ce = 1'b0; rd = 1'b0;
    ma = 2'd0; mb = 2'd0; mc = 2'd0; op = 7'h00;
    a = 6'(s - 1); b = 6'(s - 1);
    if (k <= s * t) begin
      p = (k - 1) % t;
      a = 6'((k - 1) / t);
      b = 6'd0;
      if (p == 0) begin
        ae = 1'b1;
        b = (k == 1) ? 6'(bh) : 6'(s - 1);
      end else if (p == 1) begin
        ce = 1'b1; op = 7'h35;
      end else if (p == l + 1) begin
        ma = 2'd1; mb = 2'd1; op = 7'h05; rd = (l == 1);
      end else if (p == l + 2 && l > 1) begin
        rd = 1'b1;
      end else if (p == 2 * l + 1) begin
        me = 1'b1; ma = 2'd2; mb = 2'd2; mc = 2'd1; ce = 1'b1; op = 7'h35;
      end else if (p >= 2 * l + 2) begin
        q = p - 2 * l - 2;
        b = 6'(q / 2 + 1);
        ce = 1'b1; op = 7'h35;
        if (q % 2 == 1) begin
          ma = 2'd2; mb = 2'd2; mc = 2'd1; rd = 1'b1;
        end
      end
    end else if (k == s * t + l + 1) begin
      bz = 1'b0; dn = 1'b1;
    end
    return pk(bz, dn, a, b, ae, me, ma, mb, mc, ce, op, rd);
  endfunction
  task automatic step(input bit sa, input bit ra, input bit sb, input bit rb);
    st_a = sa; rst_a = ra; st_b = sb; rst_b = rb;
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      bit st, rs;
      st = (w == 0) ? sa : sb;
      rs = (w == 0) ? ra : rb;
      if (rs) begin
        k[w] = 0; ah[w] = 0; bh[w] = 0;
      end else if (k[w] == 0) begin
        if (st) k[w] = 1;
      end else if (k[w] == s_of[w] * (2 * l_of[w] + 2 * s_of[w]) + l_of[w] + 1) begin
        k[w] = 0; ah[w] = s_of[w] - 1; bh[w] = s_of[w] - 1;
      end else k[w]++;
    end
    #1;
    for (int w = 0; w < 2; w++)
      chk($sformatf("u%0d cyc=%0d k=%0d", w, cyc, k[w]), obs(w),
          (k[w] == 0) ? pk(1'b0, 1'b0, 6'(ah[w]), 6'(bh[w]), 1'b0, 1'b0, 2'd0, 2'd0, 2'd0,
                           1'b0, 7'h00, 1'b0)
                      : exp_at(s_of[w], l_of[w], k[w], bh[w]));
    cyc++;
  endtask
  initial begin
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 0, 1, 0);
    for (int n = 0; n < 64; n++) step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    for (int n = 0; n < 19; n++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    for (int n = 0; n < 64; n++) step(0, 0, 0, 0);
    for (int n = 0; n < 140; n++) step(1, 0, 1, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    for (int n = 0; n < 70; n++) step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
